// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Single-shot SPI mode-0 master. A start request latches a 64-bit frame
// (8-bit command, 24-bit address, 32-bit data) and shifts it out MSB-first.
// During the data phase, MISO is captured into a read register at the same
// time, so that phase is full duplex.
//
// Ports:
//   clk            in   system clock; sck is derived from it
//   rst            in   asynchronous reset, active low
//   en             in   start request, accepted only in IDLE
//   cs             out  chip select, active low
//   sck            out  serial clock, idle low
//   ext_command_in in   command byte, latched at start
//   ext_address_in in   address, latched at start
//   ext_data_in    in   write data, latched at start
//   mosi           out  serial data to slave, changes on sck falling
//   miso           in   serial data from slave, sampled on sck rising
//   ext_data_out   out  last completed read word
//   done           out  one-cycle completion pulse (only when
//                       SPI_MASTER_DONE_EN is defined)
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CMD_W  = 8,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              cs,
  output logic              sck,
  input  logic [CMD_W-1:0]  ext_command_in,
  input  logic [ADDR_W-1:0] ext_address_in,
  input  logic [DATA_W-1:0] ext_data_in,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] ext_data_out
`ifdef SPI_MASTER_DONE_EN
  ,
  output logic              done
`endif
);

  localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
  localparam int MAX_W   = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                            : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam int CNT_W   = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_load;
  logic [FRAME_W-1:0] tx_shift;
  logic [DATA_W-1:0]  rx_shift;
  logic               shifting;

  assign shifting = (state == CMD) || (state == ADDR) || (state == DATA);
  assign cs       = ~shifting;

  // The gate enable changes only on clk rising edges, when ~clk is already
  // low, so the gated clock cannot glitch. The first sck rise comes half a
  // cycle after start, once the first bit has settled on mosi.
  assign sck = ~clk & shifting;

`ifdef SPI_MASTER_DONE_EN
  assign done = (state == DONE);
`endif

  // Next-state logic. Each shift phase reloads the bit counter with its own
  // field width and leaves the phase when the counter reaches zero.
  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (en) begin
          next_state   = CMD;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(CMD_W - 1);
        end
      end
      CMD: begin
        if (bit_cnt == '0) begin
          next_state   = ADDR;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(ADDR_W - 1);
        end
      end
      ADDR: begin
        if (bit_cnt == '0) begin
          next_state   = DATA;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(DATA_W - 1);
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bit counter: loaded on each phase entry and counted down while shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (cnt_load) begin
      bit_cnt <= cnt_load_val;
    end else if (shifting && (bit_cnt != '0)) begin
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  // Transmit path. The start edge presents the frame MSB directly on mosi.
  // Each later shift edge presents the next bit. The edge that leaves DATA
  // returns mosi to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
      mosi     <= 1'b0;
    end else if ((state == IDLE) && en) begin
      tx_shift <= {ext_command_in, ext_address_in, ext_data_in};
      mosi     <= ext_command_in[CMD_W-1];
    end else if (shifting) begin
      tx_shift <= tx_shift << 1;
      mosi     <= (next_state == DONE) ? 1'b0 : tx_shift[FRAME_W-2];
    end else begin
      mosi     <= 1'b0;
    end
  end

  // Receive path. miso is sampled on clk falling edges, which are the sck
  // rising edges, and only during the data phase.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift <= '0;
    end else if (state == DATA) begin
      rx_shift <= {rx_shift[DATA_W-2:0], miso};
    end
  end

  // The read word is published on the edge that enters DONE, so it is
  // already valid during the DONE cycle. An aborted frame never reaches
  // this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_data_out <= '0;
    end else if ((state == DATA) && (next_state == DONE)) begin
      ext_data_out <= rx_shift;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Randomised scoreboard bench for spi_master. The stimulus side pushes the
// expected frame (the concatenated command/address/data) and the expected read
// word into a queue. The monitor captures mosi on each sck rise and pops and
// compares the queue whenever cs returns high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

  localparam int PERIOD = 10;

  typedef struct {
    logic [63:0] frame;
    logic [31:0] rx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  cmd_in;
  logic [23:0] addr_in;
  logic [31:0] data_in;
  wire         cs;
  wire         sck;
  wire         mosi;
  wire         miso;
  wire  [31:0] data_out;
`ifdef SPI_MASTER_DONE_EN
  wire         done;
`endif

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rises    = 0;
  int          falls    = 0;
  logic [63:0] cap_bits = '0;
  time         t_start  = 0;

  // miso source: 0 = loopback of mosi, 1 = tied high, 2 = tied low,
  // 3 = a 32-bit pattern presented during the data phase
  int          miso_mode = 0;
  logic [31:0] miso_pat  = '0;
  logic        pat_bit;

  spi_master dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cs             (cs),
    .sck            (sck),
    .ext_command_in (cmd_in),
    .ext_address_in (addr_in),
    .ext_data_in    (data_in),
    .mosi           (mosi),
    .miso           (miso),
    .ext_data_out   (data_out)
`ifdef SPI_MASTER_DONE_EN
    ,
    .done           (done)
`endif
  );

  always #(PERIOD/2) clk = ~clk;

  // Before the slave samples rise n, exactly n sck falls have occurred in the
  // frame. Data-phase bit k is therefore driven while falls == 32 + k.
  assign pat_bit = (falls >= 32 && falls < 64) ? miso_pat[63 - falls] : 1'b0;
  assign miso    = (miso_mode == 0) ? mosi :
                   (miso_mode == 1) ? 1'b1 :
                   (miso_mode == 2) ? 1'b0 : pat_bit;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Push one expected result and raise en for pulse_cycles rising edges. The
  // expected read word comes from the miso source, not from the DUT.
  task automatic applyStimulus(input logic [7:0] c, input logic [23:0] a,
                               input logic [31:0] d, input int mode,
                               input logic [31:0] pat, input int pulse_cycles,
                               input bit do_push);
    exp_t e;
    @(negedge clk);
    cmd_in    = c;
    addr_in   = a;
    data_in   = d;
    miso_mode = mode;
    miso_pat  = pat;
    e.frame   = {c, a, d};
    case (mode)
      0:       e.rx = d;
      1:       e.rx = 32'hFFFF_FFFF;
      2:       e.rx = 32'h0000_0000;
      default: e.rx = pat;
    endcase
    if (do_push) exp_q.push_back(e);
    en = 1'b1;
    repeat (pulse_cycles) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic waitDrained(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cs === 1'b1) break;
    end
    if (i == 300) checkOutput({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Frame-start bookkeeping for the monitor and for the pattern driver.
  always @(negedge cs) begin
    t_start  = $time;
    rises    = 0;
    falls    = 0;
    cap_bits = '0;
  end

  always @(posedge sck) begin
    if (cs === 1'b0) begin
      cap_bits = {cap_bits[62:0], mosi};
      rises++;
    end
  end

  always @(negedge sck) begin
    if (cs === 1'b0) falls++;
  end

  // Monitor: a cs rise while reset is released marks a completed frame.
  always @(posedge cs) begin
    if (rst === 1'b1) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("mosi_frame", cap_bits, e.frame);
        checkOutput("rx_word", 64'(data_out), 64'(e.rx));
        checkOutput("sck_count", 64'(rises), 64'd64);
        checkOutput("cs_low_cycles", 64'(($time - 1 - t_start) / PERIOD), 64'd64);
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int i;
    int gap;
    logic [31:0] first_data;

    rst     = 1'b0;
    en      = 1'b0;
    cmd_in  = '0;
    addr_in = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: everything at rest and stays there with en low.
    for (int k = 0; k < 2; k++) begin
      repeat (8) @(negedge clk);
      checkOutput("idle_cs", 64'(cs), 64'd1);
      checkOutput("idle_sck", 64'(sck), 64'd0);
      checkOutput("idle_mosi", 64'(mosi), 64'd0);
      checkOutput("idle_data_out", 64'(data_out), 64'd0);
    end

    // Directed frames with a 3-cycle en pulse.
    applyStimulus(8'hA5, 24'h123456, 32'h789ABCDE, 0, 32'h0, 3, 1'b1);
    waitDrained("loopback");
    repeat (10) @(negedge clk);
    checkOutput("data_out_held", 64'(data_out), 64'h789ABCDE);

    applyStimulus(8'h00, 24'hF01234, 32'h56789ABC, 1, 32'h0, 3, 1'b1);
    waitDrained("miso_high");

    applyStimulus(8'hFF, 24'hDEF012, 32'h3456789A, 2, 32'h0, 3, 1'b1);
    waitDrained("miso_low");

    // Re-pulse en and change inputs mid-frame: only the first frame occurs.
    first_data = $urandom;
    applyStimulus(8'($urandom), 24'($urandom), first_data, 0, 32'h0, 1, 1'b1);
    repeat (10) @(negedge clk);
    cmd_in  = 8'($urandom);
    addr_in = 24'($urandom);
    data_in = $urandom;
    en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    waitDrained("midframe");
    repeat (100) @(negedge clk);
    checkOutput("midframe_data_out", 64'(data_out), 64'(first_data));

    // en held through DONE: a second frame starts after two cs-high cycles.
    begin
      exp_t e;
      @(negedge clk);
      cmd_in    = 8'h3C;
      addr_in   = 24'hA0B1C2;
      data_in   = 32'hCAFEF00D;
      miso_mode = 0;
      e.frame   = {8'h3C, 24'hA0B1C2, 32'hCAFEF00D};
      e.rx      = 32'hCAFEF00D;
      exp_q.push_back(e);
      exp_q.push_back(e);
      en = 1'b1;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cs === 1'b1 && i > 0) break;
      end
      gap = 0;
      for (int k = 0; k < 10; k++) begin
        if (cs !== 1'b1) break;
        gap++;
        @(negedge clk);
      end
      en = 1'b0;
      checkOutput("cs_high_gap", 64'(gap), 64'd2);
      waitDrained("back_to_back");
    end

    // Randomised frames over all miso sources and pulse lengths.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'($urandom), 24'($urandom), $urandom,
                    int'($urandom_range(3, 0)), $urandom,
                    int'($urandom_range(3, 1)), 1'b1);
      waitDrained("random");
    end

    // Reset at bit 20 aborts the frame at once.
    applyStimulus(8'h5A, 24'h0F0F0F, 32'h12345678, 0, 32'h0, 1, 1'b0);
    for (i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rises >= 20) break;
    end
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_cs", 64'(cs), 64'd1);
    checkOutput("abort_sck", 64'(sck), 64'd0);
    checkOutput("abort_mosi", 64'(mosi), 64'd0);
    checkOutput("abort_data_out", 64'(data_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_abort_cs", 64'(cs), 64'd1);

    applyStimulus(8'($urandom), 24'($urandom), $urandom, 3, $urandom, 1, 1'b1);
    waitDrained("post_abort");

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
